wb_port_arbiter: RTL

- Arbitrates the single register-file write port between the in-order pipeline writeback stream and out-of-order results from the long-latency unit (LLU: mul/div, cache ops).
- Sits between WB and the RegFile. Holds LLU results in a 2-entry FIFO.
- Guarantees LLU forward progress with a starvation counter.
- Suppresses stale LLU writes that a younger pipeline write overwrites (WAW kill).

---
 rtl/wb_port_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order writeback
// stream and out-of-order long-latency-unit (LLU) results. LLU results wait in
// a 2-entry FIFO. A starvation counter stalls the pipe so that a waiting LLU
// result is eventually written. A pipe write to register N cancels every older
// queued LLU write to N (WAW kill), so a stale value never lands after a newer one.

module wb_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid_i,
  input  logic [4:0]  pipe_num_i,
  input  logic [31:0] pipe_data_i,
  output logic        pipe_ready_o,
  input  logic        llu_valid_i,
  input  logic [4:0]  llu_num_i,
  input  logic [31:0] llu_data_i,
  output logic        llu_ready_o,
  output logic        rf_wen_o,
  output logic [4:0]  rf_wnum_o,
  output logic [31:0] rf_wdata_o,
  output logic        llu_pending_o,
  output logic [1:0]  fifo_count_o
);

  localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);
  localparam int unsigned DEPTH = 2;

  // FIFO storage and bookkeeping
  logic [4:0]  fifo_num_r  [DEPTH];
  logic [31:0] fifo_data_r [DEPTH];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic [2:0]  starve_cnt_r;

  // Registered write port
  logic        rf_wen_r;
  logic [4:0]  rf_wnum_r;
  logic [31:0] rf_wdata_r;

  // Decode of the current cycle
  logic        pending_s;
  logic        starve_force_s;
  logic        pipe_ready_s;
  logic        llu_ready_s;
  logic [4:0]  head_num_s;
  logic [31:0] head_data_s;
  logic        head_null_s;
  logic        pipe_grant_s;
  logic        head_grant_s;
  logic        deq_s;
  logic        enq_s;
  logic [4:0]  enq_num_s;

  // Next-state values
  logic [4:0]  num_nxt_s  [DEPTH];
  logic [31:0] data_nxt_s [DEPTH];
  logic [1:0]  count_nxt_s;
  logic [2:0]  starve_nxt_s;
  logic        rf_wen_nxt_s;
  logic [4:0]  rf_wnum_nxt_s;
  logic [31:0] rf_wdata_nxt_s;

  // Status flags depend only on registered state, never on this cycle's inputs.
  assign pending_s      = (count_r != 2'd0);
  assign starve_force_s = pending_s && (starve_cnt_r == STARVE_LIMIT);
  assign pipe_ready_s   = !starve_force_s;
  assign llu_ready_s    = (count_r < 2'd2);
  assign head_num_s     = fifo_num_r[rd_ptr_r];
  assign head_data_s    = fifo_data_r[rd_ptr_r];

  // Grant selection: a null/killed head drains for free, then the pipe, then a live head.
  always_comb begin
    head_null_s  = 1'b0;
    pipe_grant_s = 1'b0;
    head_grant_s = 1'b0;
    if (pending_s && (head_num_s == 5'd0)) begin
      head_null_s = 1'b1;
    end else begin
      head_null_s = 1'b0;
    end
    if (pipe_valid_i && pipe_ready_s && (pipe_num_i != 5'd0)) begin
      pipe_grant_s = 1'b1;
    end else begin
      pipe_grant_s = 1'b0;
    end
    if (pending_s && !head_null_s && !pipe_grant_s) begin
      head_grant_s = 1'b1;
    end else begin
      head_grant_s = 1'b0;
    end
  end

  assign deq_s = head_null_s || head_grant_s;
  assign enq_s = llu_valid_i && llu_ready_s;

  // A same-cycle enqueue targeting the register the pipe writes is already stale.
  always_comb begin
    enq_num_s = llu_num_i;
    if (pipe_grant_s && (llu_num_i == pipe_num_i)) begin
      enq_num_s = 5'd0;
    end else begin
      enq_num_s = llu_num_i;
    end
  end

  // Per-entry next contents: WAW kill on pipe grant, then overwrite on enqueue.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      num_nxt_s[i]  = fifo_num_r[i];
      data_nxt_s[i] = fifo_data_r[i];
      if (pipe_grant_s && (fifo_num_r[i] == pipe_num_i)) begin
        num_nxt_s[i] = 5'd0;
      end else begin
        num_nxt_s[i] = fifo_num_r[i];
      end
      if (enq_s && (wr_ptr_r == i[0])) begin
        num_nxt_s[i]  = enq_num_s;
        data_nxt_s[i] = llu_data_i;
      end else begin
        data_nxt_s[i] = fifo_data_r[i];
      end
    end
  end

  // Occupancy update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({enq_s, deq_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Starvation counter: counts cycles the head has lost, saturating at the limit.
  always_comb begin
    starve_nxt_s = starve_cnt_r;
    if (!pending_s || deq_s) begin
      starve_nxt_s = 3'd0;
    end else if (starve_cnt_r < STARVE_LIMIT) begin
      starve_nxt_s = starve_cnt_r + 3'd1;
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Write-port mux; number and data hold when nothing is granted.
  always_comb begin
    rf_wen_nxt_s   = 1'b0;
    rf_wnum_nxt_s  = rf_wnum_r;
    rf_wdata_nxt_s = rf_wdata_r;
    if (pipe_grant_s) begin
      rf_wen_nxt_s   = 1'b1;
      rf_wnum_nxt_s  = pipe_num_i;
      rf_wdata_nxt_s = pipe_data_i;
    end else if (head_grant_s) begin
      rf_wen_nxt_s   = 1'b1;
      rf_wnum_nxt_s  = head_num_s;
      rf_wdata_nxt_s = head_data_s;
    end else begin
      rf_wen_nxt_s   = 1'b0;
      rf_wnum_nxt_s  = rf_wnum_r;
      rf_wdata_nxt_s = rf_wdata_r;
    end
  end

  // FIFO storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_num_r[i]  <= 5'd0;
        fifo_data_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_num_r[i]  <= num_nxt_s[i];
        fifo_data_r[i] <= data_nxt_s[i];
      end
    end
  end

  // Pointers, occupancy and starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r     <= 1'b0;
      wr_ptr_r     <= 1'b0;
      count_r      <= 2'd0;
      starve_cnt_r <= 3'd0;
    end else begin
      rd_ptr_r     <= deq_s ? ~rd_ptr_r : rd_ptr_r;
      wr_ptr_r     <= enq_s ? ~wr_ptr_r : wr_ptr_r;
      count_r      <= count_nxt_s;
      starve_cnt_r <= starve_nxt_s;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen_r   <= 1'b0;
      rf_wnum_r  <= 5'd0;
      rf_wdata_r <= 32'd0;
    end else begin
      rf_wen_r   <= rf_wen_nxt_s;
      rf_wnum_r  <= rf_wnum_nxt_s;
      rf_wdata_r <= rf_wdata_nxt_s;
    end
  end

  assign pipe_ready_o  = pipe_ready_s;
  assign llu_ready_o   = llu_ready_s;
  assign llu_pending_o = pending_s;
  assign fifo_count_o  = count_r;
  assign rf_wen_o      = rf_wen_r;
  assign rf_wnum_o     = rf_wnum_r;
  assign rf_wdata_o    = rf_wdata_r;

endmodule
